// File: rtl/rd_8bit_down_timer.sv
// rd_8bit_down_timer: loadable down-counter with an IDLE/RUN/DONE sequencer.
//   Q counts down from a loaded value while running and enabled; Done pulses
//   for one cycle when the count is exhausted; TC flags Q==0 combinationally.
// Optional feature macro: RD_DOWN_AUTORELOAD_EN
//   When defined, a reload register captures D on every Load, and DONE with
//   Periodic=1 restarts the count from that value. When undefined, no reload
//   register exists, Periodic has no effect and DONE always returns to IDLE.
// Clr is an asynchronous, active-high reset.
module rd_8bit_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic             Periodic,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] reload_val;
    logic             reload_allowed;

`ifdef RD_DOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_reg;

    // Reload register: remembers the most recent Load value for periodic restarts.
    always_ff @(posedge CLK or posedge Clr) begin
        if (Clr) begin
            reload_reg <= '0;
        end else if (Load) begin
            reload_reg <= D;
        end
    end

    assign reload_val     = reload_reg;
    assign reload_allowed = Periodic;
`else
    // Without the feature the restart path is tied off; Periodic is masked so
    // DONE always falls through to IDLE.
    assign reload_val     = '0;
    assign reload_allowed = Periodic & 1'b0;
`endif

    // State and count registers, cleared asynchronously by Clr.
    always_ff @(posedge CLK or posedge Clr) begin
        if (Clr) begin
            state_reg <= IDLE;
            q_reg     <= '0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
        end
    end

    // Next-state and next-count: Load always wins over counting; RUN leaves at Q==1
    // so the count never wraps below zero.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        case (state_reg)
            IDLE: begin
                if (Load) begin
                    q_next = D;
                end
                // The zero-length check looks at the value Q is about to take,
                // so a same-cycle Load of 0 with Start goes straight to DONE.
                if (Start) begin
                    if (q_next == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (Load) begin
                    // Retrigger: restart the count from D, or finish if D is 0.
                    q_next = D;
                    if (D == '0) begin
                        state_next = DONE;
                    end
                end else if (En) begin
                    if (q_reg <= ONE) begin
                        q_next     = '0;
                        state_next = DONE;
                    end else begin
                        q_next = q_reg - ONE;
                    end
                end
            end
            DONE: begin
                if (Load) begin
                    // An explicit Load ends the cycle and overrides any reload.
                    q_next     = D;
                    state_next = IDLE;
                end else if (reload_allowed) begin
                    q_next = reload_val;
                    if (reload_val == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    q_next     = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                q_next     = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign Q    = q_reg;
    assign TC   = (q_reg == '0);
    assign Busy = (state_reg == RUN);
    assign Done = (state_reg == DONE);

endmodule

// File: doc/rd_8bit_down_timer.md
RD_8BIT_DOWN_TIMER -- requirements
Module: rd_8bit_down_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/load width in bits.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port Clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port En  input  1  count enable; decrement occurs only in RUN with En=1.
REQ-005 SHALL have port Load  input  1  synchronous load strobe for D.
REQ-006 SHALL have port D  input  WIDTH  load value.
REQ-007 SHALL have port Start  input  1  synchronous start strobe, honoured in IDLE only.
REQ-008 SHALL have port Periodic  input  1  auto-reload request (see Configuration).
REQ-009 SHALL have port Q  output  WIDTH  registered count value.
REQ-010 SHALL have port TC  output  1  combinational terminal count, 1 when Q==0.
REQ-011 SHALL have port Busy  output  1  1 while state==RUN.
REQ-012 SHALL have port Done  output  1  1 for exactly the one cycle state==DONE.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, RUN, DONE.
REQ-014 IDLE: Q holds; Start=1 with next-Q!=0 -> RUN; Start=1 with next-Q==0 -> DONE (zero-length run).
REQ-015 RUN, En=0: Q holds, state holds.
REQ-016 RUN, En=1, Q>1: Q<=Q-1, stay RUN.
REQ-017 RUN, En=1, Q==1: Q<=0, -> DONE; terminal transition takes exactly Q_start cycles of En=1 after entering RUN.
REQ-018 DONE: unconditional single cycle; next state per REQ-027/REQ-028.
REQ-019 Load=1 in any state: Q<=D next edge; Load has priority over decrement in the same cycle.
REQ-020 Load in IDLE with Start=1 same cycle: Q<=D and zero check of REQ-014 uses D.
REQ-021 Load in RUN: Q<=D, stay RUN (retrigger); if D==0 -> DONE.
REQ-022 Load in DONE: Q<=D, -> IDLE, overrides any reload.
REQ-023 Start in RUN or DONE SHALL be ignored.
REQ-024 Q arithmetic SHALL be modulo 2^WIDTH; Q never decrements below 0 (no underflow wrap), since RUN exits at Q==1.

Reset
REQ-025 Clr=1 SHALL, asynchronously and independent of CLK, force Q=0, reload register=0, state=IDLE, Busy=0, Done=0 (TC=1).
REQ-026 Clr asserted mid-RUN SHALL abort the run with no Done pulse; after release the block waits in IDLE for Start.

Configuration
REQ-027 Macro RD_DOWN_AUTORELOAD_EN defined: a WIDTH-bit reload register SHALL capture D on every Load; in DONE with Periodic=1, Q<=reload value and -> RUN (or -> DONE again if reload value==0, giving Done every cycle); with Periodic=0, -> IDLE, Q stays 0.
REQ-028 Macro undefined: no reload register SHALL be built, Periodic SHALL be ignored (port retained), DONE always -> IDLE with Q=0.

Verification
REQ-029 Clr pulse mid-RUN at Q=5 -> Q=0, Busy=0, Done=0 immediately, TC=1; no Done afterwards.
REQ-030 Load D=3, Start, En=1 constant -> Q 3,2,1,0; Busy high 3 cycles; Done high 1 cycle after Q reaches 0; then IDLE.
REQ-031 Load D=4, Start, En toggled 1,0,1,0,... -> Q decrements only on En=1 cycles; Done after 4th enabled cycle.
REQ-032 Load D=0 with Start same cycle -> no RUN, Done high next cycle, Busy never high.
REQ-033 In RUN at Q=2 with Load D=7 and En=1 same cycle -> Q=7, stay RUN; Done after 7 further enabled cycles.
REQ-034 With RD_DOWN_AUTORELOAD_EN, Load D=2, Periodic=1, Start, En=1 -> Done every 3 cycles, Q sequence 2,1,0,2,1,0; without macro -> single Done, then IDLE with Q=0.
